// File: rtl/instream_bank.sv
// instream_bank: multi-channel replay buffer feeding the node-array input
// ports. Each channel holds a preloaded word buffer and streams it out over a
// valid/ready handshake at one word per cycle, with optional looping, abort
// and a done pulse at the end of a non-looping stream.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | channel parked, out_valid low, length may be rewritten
//   S_RUN  | out_data/out_valid present buf[idx], advancing on each transfer
//
// The word for the next beat is read combinationally from the buffer and
// captured into out_data at the transfer edge, so there is no bubble between
// words and a later load to the presented address cannot disturb out_data.
module instream_bank #(
  parameter  int WIDTH = 11,
  parameter  int DEPTH = 64,
  parameter  int NCH   = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load_en,
  input  logic [CW-1:0]        i_load_ch,
  input  logic [AW-1:0]        i_load_addr,
  input  logic [WIDTH-1:0]     i_load_data,
  input  logic                 i_len_we,
  input  logic [AW:0]          i_len_val,
  input  logic [NCH-1:0]       i_start,
  input  logic [NCH-1:0]       i_stop,
  input  logic [NCH-1:0]       i_loop,
  input  logic [NCH-1:0]       i_out_ready,
  output logic [NCH-1:0]       o_out_valid,
  output logic [NCH*WIDTH-1:0] o_out_data,
  output logic [NCH-1:0]       o_busy,
  output logic [NCH-1:0]       o_done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  // Lengths above DEPTH would index past the buffer, so saturate them here.
  logic [AW:0] w_len_clamped;
  assign w_len_clamped = (i_len_val > LEN_MAX) ? LEN_MAX : i_len_val;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [WIDTH-1:0] r_mem [DEPTH];
    state_t           r_state;
    logic [AW:0]      r_idx;
    logic [AW:0]      r_len;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_done;

    logic             w_sel;
    logic             w_xfer;
    logic             w_more;
    logic [AW:0]      w_nidx;
    logic [WIDTH-1:0] w_word0;
    logic [WIDTH-1:0] w_wordn;

    assign w_sel   = (i_load_ch == CW'(c));
    assign w_xfer  = r_valid & i_out_ready[c];
    assign w_nidx  = r_idx + 1'b1;
    // Unsigned AW+1-bit compare: len = DEPTH ends cleanly after word DEPTH-1.
    assign w_more  = (w_nidx < r_len);
    assign w_word0 = r_mem[0];
    assign w_wordn = r_mem[w_nidx[AW-1:0]];

    // Buffer write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
      if (i_load_en && w_sel) begin
        r_mem[i_load_addr] <= i_load_data;
      end
    end

    // Channel sequencer: length register, handshake data path and done pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_len   <= '0;
        r_data  <= '0;
        r_valid <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_done <= 1'b0;
        // A length change under a running or just-starting stream is dropped.
        if (i_len_we && w_sel && (r_state == S_IDLE) && !i_start[c]) begin
          r_len <= w_len_clamped;
        end
        case (r_state)
          S_IDLE: begin
            if (i_start[c] && !i_stop[c]) begin
              if (r_len != '0) begin
                r_state <= S_RUN;
                r_idx   <= '0;
                r_data  <= w_word0;
                r_valid <= 1'b1;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (i_stop[c]) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
            end else if (w_xfer) begin
              if (w_more) begin
                r_idx  <= w_nidx;
                r_data <= w_wordn;
              end else if (i_loop[c]) begin
                r_idx  <= '0;
                r_data <= w_word0;
              end else begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end

    assign o_out_valid[c]                = r_valid;
    assign o_out_data[c*WIDTH +: WIDTH]  = r_data;
    assign o_busy[c]                     = (r_state == S_RUN);
    assign o_done[c]                     = r_done;
  end

endmodule

// File: tb/tb_instream_bank.sv
// Directed bench for instream_bank (WIDTH 11, DEPTH 64, NCH 4).
module tb_instream_bank;
  localparam int WIDTH = 11;
  localparam int DEPTH = 64;
  localparam int NCH   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_load_en;
  logic [1:0]       i_load_ch;
  logic [5:0]       i_load_addr;
  logic [10:0]      i_load_data;
  logic             i_len_we;
  logic [6:0]       i_len_val;
  logic [3:0]       i_start;
  logic [3:0]       i_stop;
  logic [3:0]       i_loop;
  logic [3:0]       i_out_ready;
  logic [3:0]       o_out_valid;
  logic [43:0]      o_out_data;
  logic [3:0]       o_busy;
  logic [3:0]       o_done;

  int nvec = 0;
  int nerr = 0;

  instream_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_load_en   (i_load_en),
    .i_load_ch   (i_load_ch),
    .i_load_addr (i_load_addr),
    .i_load_data (i_load_data),
    .i_len_we    (i_len_we),
    .i_len_val   (i_len_val),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_loop      (i_loop),
    .i_out_ready (i_out_ready),
    .o_out_valid (o_out_valid),
    .o_out_data  (o_out_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] dat(input int c);
    return o_out_data[c*WIDTH +: WIDTH];
  endfunction

  task automatic load(input int ch, input int addr, input int data);
    i_load_en   = 1'b1;
    i_load_ch   = 2'(ch);
    i_load_addr = 6'(addr);
    i_load_data = 11'(data);
    tick;
    i_load_en   = 1'b0;
  endtask

  task automatic setlen(input int ch, input int len);
    i_len_we  = 1'b1;
    i_load_ch = 2'(ch);
    i_len_val = 7'(len);
    tick;
    i_len_we  = 1'b0;
  endtask

  // Channel ch: valid, data, busy, done in one go.
  task automatic chk_ch(input string tag, input int ch, input logic v,
                        input logic [10:0] d, input logic b, input logic dn);
    chk({tag, "_valid"}, 32'(o_out_valid[ch]), 32'(v));
    if (v) chk({tag, "_data"}, 32'(dat(ch)), 32'(d));
    chk({tag, "_busy"}, 32'(o_busy[ch]), 32'(b));
    chk({tag, "_done"}, 32'(o_done[ch]), 32'(dn));
  endtask

  initial begin
    int xfers;
    int m3;
    logic r3;

    rst = 1'b1;
    i_load_en = 0; i_load_ch = 0; i_load_addr = 0; i_load_data = 0;
    i_len_we = 0; i_len_val = 0;
    i_start = 0; i_stop = 0; i_loop = 0; i_out_ready = 0;
    #12;
    chk("rst_valid", 32'(o_out_valid), 32'h0);
    chk("rst_data",  32'(o_out_data[31:0]), 32'h0);
    chk("rst_data_hi", 32'(o_out_data[43:32]), 32'h0);
    chk("rst_busy",  32'(o_busy), 32'h0);
    chk("rst_done",  32'(o_done), 32'h0);
    rst = 1'b0;
    tick;

    // 1: ch0, 5 words, ready held high
    for (int i = 0; i < 5; i++) load(0, i, i + 1);
    setlen(0, 5);
    i_start = 4'b0001; i_out_ready = 4'b0001;
    tick;
    i_start = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      chk_ch($sformatf("t1_w%0d", k), 0, 1'b1, 11'(k + 1), 1'b1, 1'b0);
      tick;
    end
    chk_ch("t1_end", 0, 1'b0, 11'h0, 1'b0, 1'b1);
    tick;
    chk_ch("t1_after", 0, 1'b0, 11'h0, 1'b0, 1'b0);
    i_out_ready = 4'b0000;

    // 2: ch1, 3 words, ready 1,0,0,1,1 with a load to the presented address
    load(1, 0, 11'h011); load(1, 1, 11'h022); load(1, 2, 11'h033);
    setlen(1, 3);
    i_start = 4'b0010;
    tick;
    i_start = 4'b0000;
    xfers = 0;
    chk_ch("t2_s", 1, 1'b1, 11'h011, 1'b1, 1'b0);
    i_out_ready = 4'b0010; if (o_out_valid[1]) xfers++;
    tick;
    chk_ch("t2_a", 1, 1'b1, 11'h022, 1'b1, 1'b0);
    i_out_ready = 4'b0000;
    i_load_en = 1'b1; i_load_ch = 2'd1; i_load_addr = 6'd1; i_load_data = 11'h0AA;
    tick;
    i_load_en = 1'b0;
    chk_ch("t2_b", 1, 1'b1, 11'h022, 1'b1, 1'b0);
    tick;
    chk_ch("t2_c", 1, 1'b1, 11'h022, 1'b1, 1'b0);
    i_out_ready = 4'b0010; if (o_out_valid[1]) xfers++;
    tick;
    chk_ch("t2_d", 1, 1'b1, 11'h033, 1'b1, 1'b0);
    if (o_out_valid[1]) xfers++;
    tick;
    chk_ch("t2_end", 1, 1'b0, 11'h0, 1'b0, 1'b1);
    chk("t2_xfers", 32'(xfers), 32'd3);
    i_out_ready = 4'b0000;

    // 3: ch2 looping 2-word stream; len write while running is dropped
    load(2, 0, 11'h7FF); load(2, 1, 11'h400);
    setlen(2, 2);
    i_loop = 4'b0100; i_start = 4'b0100; i_out_ready = 4'b0100;
    tick;
    i_start = 4'b0000;
    chk_ch("t3_w0", 2, 1'b1, 11'h7FF, 1'b1, 1'b0);
    i_len_we = 1'b1; i_load_ch = 2'd2; i_len_val = 7'd1;
    for (int k = 1; k < 6; k++) begin
      tick;
      i_len_we = 1'b0;
      chk_ch($sformatf("t3_w%0d", k), 2, 1'b1, (k % 2 == 1) ? 11'h400 : 11'h7FF, 1'b1, 1'b0);
    end
    i_loop = 4'b0000;
    tick;
    chk_ch("t3_end", 2, 1'b0, 11'h0, 1'b0, 1'b1);
    i_out_ready = 4'b0000;

    // 4a: zero-length start on ch3
    setlen(3, 0);
    i_start = 4'b1000; i_out_ready = 4'b1000;
    tick;
    i_start = 4'b0000;
    chk_ch("t4_len0", 3, 1'b0, 11'h0, 1'b0, 1'b1);
    tick;
    chk_ch("t4_len0_after", 3, 1'b0, 11'h0, 1'b0, 1'b0);
    i_out_ready = 4'b0000;

    // 4b: full-depth ramp on ch0, length written as 100 and saturated to 64
    for (int i = 0; i < DEPTH; i++) load(0, i, 11'h200 + i);
    setlen(0, 100);
    i_start = 4'b0001; i_out_ready = 4'b0001;
    tick;
    i_start = 4'b0000;
    for (int k = 0; k < DEPTH; k++) begin
      chk_ch($sformatf("t4_w%0d", k), 0, 1'b1, 11'(11'h200 + k), 1'b1, 1'b0);
      tick;
    end
    chk_ch("t4_end", 0, 1'b0, 11'h0, 1'b0, 1'b1);
    i_out_ready = 4'b0000;

    // 5: ch3 5-word stream, stop on 3rd word; len write with start is dropped
    for (int i = 0; i < 5; i++) load(3, i, 11'h031 + i);
    setlen(3, 5);
    i_start = 4'b1000; i_out_ready = 4'b1000;
    i_len_we = 1'b1; i_load_ch = 2'd3; i_len_val = 7'd2;
    tick;
    i_start = 4'b0000; i_len_we = 1'b0;
    chk_ch("t5_w0", 3, 1'b1, 11'h031, 1'b1, 1'b0);
    tick;
    chk_ch("t5_w1", 3, 1'b1, 11'h032, 1'b1, 1'b0);
    tick;
    chk_ch("t5_w2", 3, 1'b1, 11'h033, 1'b1, 1'b0);
    i_out_ready = 4'b0000; i_stop = 4'b1000;
    tick;
    i_stop = 4'b0000;
    chk_ch("t5_stop", 3, 1'b0, 11'h0, 1'b0, 1'b0);
    tick;
    chk_ch("t5_stop2", 3, 1'b0, 11'h0, 1'b0, 1'b0);
    i_start = 4'b1000; i_out_ready = 4'b1000;
    tick;
    i_start = 4'b0000;
    chk_ch("t5_r0", 3, 1'b1, 11'h031, 1'b1, 1'b0);
    tick;
    chk_ch("t5_r1", 3, 1'b1, 11'h032, 1'b1, 1'b0);
    tick;
    chk_ch("t5_r2", 3, 1'b1, 11'h033, 1'b1, 1'b0);
    i_start = 4'b1000;
    tick;
    i_start = 4'b0000;
    chk_ch("t5_r3", 3, 1'b1, 11'h034, 1'b1, 1'b0);
    tick;
    chk_ch("t5_r4", 3, 1'b1, 11'h035, 1'b1, 1'b0);
    tick;
    chk_ch("t5_end", 3, 1'b0, 11'h0, 1'b0, 1'b1);
    i_out_ready = 4'b0000;

    // start with stop in the same cycle: stop wins
    i_start = 4'b1000; i_stop = 4'b1000;
    tick;
    i_start = 4'b0000; i_stop = 4'b0000;
    chk_ch("t5_startstop", 3, 1'b0, 11'h0, 1'b0, 1'b0);

    // 6: ch0 and ch3 concurrently with different ready patterns
    i_start = 4'b1001; i_out_ready = 4'b0001;
    tick;
    i_start = 4'b0000;
    chk_ch("t6_c0_0", 0, 1'b1, 11'h200, 1'b1, 1'b0);
    chk_ch("t6_c3_0", 3, 1'b1, 11'h031, 1'b1, 1'b0);
    m3 = 0;
    for (int k = 1; k <= 4; k++) begin
      r3 = (k % 2 == 0);
      i_out_ready = {r3, 2'b00, 1'b1};
      tick;
      if (r3) m3++;
      chk_ch($sformatf("t6_c0_%0d", k), 0, 1'b1, 11'(11'h200 + k), 1'b1, 1'b0);
      chk_ch($sformatf("t6_c3_%0d", k), 3, 1'b1, 11'(11'h031 + m3), 1'b1, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(o_out_valid), 32'h0);
    chk("t6_rst_data",  32'(o_out_data[31:0]), 32'h0);
    chk("t6_rst_data_hi", 32'(o_out_data[43:32]), 32'h0);
    chk("t6_rst_busy",  32'(o_busy), 32'h0);
    #2;
    rst = 1'b0;
    i_out_ready = 4'b1111;
    tick;
    chk("t6_post_valid", 32'(o_out_valid), 32'h0);
    i_start = 4'b1001;
    tick;
    i_start = 4'b0000;
    chk("t6_len0_done",  32'(o_done), 32'h9);
    chk("t6_len0_valid", 32'(o_out_valid), 32'h0);
    chk("t6_len0_busy",  32'(o_busy), 32'h0);
    tick;
    chk("t6_len0_after", 32'(o_done), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
